k2_program_loader: RTL and testbench

//  Loadable program store for the K2 processor; successor to the fixed instruction ROM top level.

---
 rtl/k2_pkg.sv | 14 +
 rtl/k2_prog_ram.sv | 22 ++
 rtl/k2_program_loader.sv | 114 +++++++++++
 tb/tb_k2_program_loader.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// Shared types and defaults for the K2 loadable program store.
package k2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      RUN   = 2'd3
   } k2_ldr_state_t;

   // K2 NOP encoding, returned for addresses beyond the loaded program
   localparam logic [7:0] K2_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/k2_prog_ram.sv
// Program storage: synchronous write, asynchronous read, no reset on contents.
module k2_prog_ram #(
   parameter int unsigned INST_W = 8,
   parameter int unsigned ADDR_W = 4
)(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [INST_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [INST_W-1:0] rdata
);

   logic [INST_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/k2_program_loader.sv
// Loadable K2 program store: streams a program in, then releases the processor from reset.
module k2_program_loader
   import k2_pkg::*;
#(
   parameter int unsigned       INST_W = 8,
   parameter int unsigned       ADDR_W = 4,
   parameter logic [INST_W-1:0] FILL   = INST_W'(K2_FILL_DEFAULT)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [INST_W-1:0] load_data,
   input  logic              load_last,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [INST_W-1:0] cpu_inst,
   output logic              cpu_rst_n,
   output logic [ADDR_W:0]   prog_len,
   output logic [INST_W-1:0] checksum,
   output logic              overflow,
   output logic [1:0]        state_o
);

   localparam int unsigned     DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH-1);

   k2_ldr_state_t     state_q, state_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic [INST_W-1:0] checksum_q, checksum_d;
   logic              overflow_q, overflow_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;

   logic              load_ready_int;
   logic              beat;
   logic              wr_en;
   logic [ADDR_W:0]   base_len;
   logic [INST_W-1:0] base_ck;
   logic [INST_W-1:0] rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prog_len_q  <= '0;
         checksum_q  <= '0;
         overflow_q  <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_len_q  <= prog_len_d;
         checksum_q  <= checksum_d;
         overflow_q  <= overflow_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   // A beat accepted from IDLE starts a fresh program, so length/checksum restart from zero.
   always_comb begin
      state_d    = state_q;
      prog_len_d = prog_len_q;
      checksum_d = checksum_q;
      overflow_d = overflow_q;
      wr_en      = 1'b0;
      base_len   = (state_q == IDLE) ? '0 : prog_len_q;
      base_ck    = (state_q == IDLE) ? '0 : checksum_q;
      beat       = load_valid && load_ready_int && !abort;
      if (abort) begin
         state_d = IDLE;
         if (state_q == IDLE || state_q == LOAD) prog_len_d = '0;
      end else begin
         case (state_q)
            IDLE, LOAD: begin
               if (beat) begin
                  wr_en      = 1'b1;
                  prog_len_d = base_len + 1'b1;
                  checksum_d = base_ck ^ load_data;
                  overflow_d = (base_len == LAST_SLOT);
                  state_d    = (load_last || base_len == LAST_SLOT) ? READY : LOAD;
               end
            end
            READY:   if (start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      load_ready_int = (state_q == IDLE) || (state_q == LOAD);
      cpu_rst_n_d    = (state_q == RUN);
   end

   k2_prog_ram #(
      .INST_W (INST_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (base_len[ADDR_W-1:0]),
      .wdata (load_data),
      .raddr (cpu_addr),
      .rdata (rd_data)
   );

   assign cpu_inst   = ({1'b0, cpu_addr} < prog_len_q) ? rd_data : FILL;
   assign load_ready = load_ready_int;
   assign cpu_rst_n  = cpu_rst_n_q;
   assign prog_len   = prog_len_q;
   assign checksum   = checksum_q;
   assign overflow   = overflow_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_k2_program_loader.sv
// Directed self-checking bench for k2_program_loader (INST_W=8, ADDR_W=4, FILL=8'h00).
module tb_k2_program_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic       load_last;
   logic       start;
   logic       abort;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_inst;
   logic       cpu_rst_n;
   logic [4:0] prog_len;
   logic [7:0] checksum;
   logic       overflow;
   logic [1:0] state_o;

   int tests = 0;
   int fails = 0;

   k2_program_loader #(
      .INST_W (8),
      .ADDR_W (4),
      .FILL   (8'h00)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .start      (start),
      .abort      (abort),
      .cpu_addr   (cpu_addr),
      .cpu_inst   (cpu_inst),
      .cpu_rst_n  (cpu_rst_n),
      .prog_len   (prog_len),
      .checksum   (checksum),
      .overflow   (overflow),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = l;
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      start = 1'b0; abort = 1'b0; cpu_addr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset values
      check("rst_state", state_o, 0);
      check("rst_len", prog_len, 0);
      check("rst_ck", checksum, 0);
      check("rst_ovf", overflow, 0);
      check("rst_cpu_rst_n", cpu_rst_n, 0);
      check("rst_ready", load_ready, 1);
      check("rst_inst_fill", cpu_inst, 8'h00);

      // async reset mid-load
      beat(8'h55, 1'b0);
      check("mid_state_load", state_o, 1);
      check("mid_len1", prog_len, 1);
      #2 rst = 1'b1;
      #1;
      check("async_state", state_o, 0);
      check("async_len", prog_len, 0);
      check("async_cpu_rst_n", cpu_rst_n, 0);
      check("async_ready", load_ready, 1);
      tick();
      rst = 1'b0;

      // 3-word program
      beat(8'hA1, 1'b0);
      beat(8'hB2, 1'b0);
      beat(8'hC3, 1'b1);
      check("p3_state", state_o, 2);
      check("p3_len", prog_len, 3);
      check("p3_ck", checksum, 8'hD0);
      check("p3_ovf", overflow, 0);
      check("p3_ready", load_ready, 0);
      cpu_addr = 4'd1; #1 check("p3_rd1", cpu_inst, 8'hB2);
      cpu_addr = 4'd2; #1 check("p3_rd2", cpu_inst, 8'hC3);
      cpu_addr = 4'd3; #1 check("p3_rd3_fill", cpu_inst, 8'h00);
      cpu_addr = 4'd5; #1 check("p3_rd5_fill", cpu_inst, 8'h00);

      // start / run / abort timing
      start = 1'b1; tick(); start = 1'b0;
      check("run_state", state_o, 3);
      check("run_rst_n_lag", cpu_rst_n, 0);
      tick();
      check("run_rst_n", cpu_rst_n, 1);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_run_state", state_o, 0);
      tick();
      check("abort_run_rst_n", cpu_rst_n, 0);

      // 16 words without last, then a 17th offered
      for (int i = 0; i < 16; i++) beat(8'(i + 1), 1'b0);
      check("ovf_state", state_o, 2);
      check("ovf_len", prog_len, 16);
      check("ovf_flag", overflow, 1);
      check("ovf_ck", checksum, 8'h10);
      cpu_addr = 4'd15; #1 check("ovf_rd15", cpu_inst, 8'h10);
      cpu_addr = 4'd0;
      load_valid = 1'b1; load_data = 8'h99; #1;
      check("ovf_17_ready", load_ready, 0);
      tick(); load_valid = 1'b0;
      check("bp_len", prog_len, 16);
      check("bp_rd0", cpu_inst, 8'h01);
      check("bp_state", state_o, 2);

      // abort beats start in READY
      abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
      check("prio_state", state_o, 0);
      tick();
      check("prio_rst_n", cpu_rst_n, 0);

      // reload: first beat clears old length/checksum/overflow, read-before-write on same address
      cpu_addr = 4'd0;
      load_valid = 1'b1; load_data = 8'h11; load_last = 1'b0; #1;
      check("rl_old_word", cpu_inst, 8'h01);
      tick(); load_valid = 1'b0;
      check("rl_new_word", cpu_inst, 8'h11);
      check("rl_ovf_clr", overflow, 0);
      check("rl_ck1", checksum, 8'h11);
      check("rl_len1", prog_len, 1);
      check("rl_state1", state_o, 1);
      beat(8'h22, 1'b1);
      check("rl_ck2", checksum, 8'h33);
      check("rl_len2", prog_len, 2);
      check("rl_state2", state_o, 2);
      cpu_addr = 4'd5; #1 check("rl_stale_fill", cpu_inst, 8'h00);
      cpu_addr = 4'd1; #1 check("rl_rd1", cpu_inst, 8'h22);
      start = 1'b1; tick(); start = 1'b0; tick();
      check("rl_run_rst_n", cpu_rst_n, 1);
      abort = 1'b1; tick(); abort = 1'b0; tick();
      check("rl_abort_state", state_o, 0);
      check("rl_abort_rst_n", cpu_rst_n, 0);

      // abort during LOAD, with a same-cycle beat
      beat(8'h77, 1'b0);
      beat(8'h88, 1'b0);
      check("la_len2", prog_len, 2);
      check("la_state", state_o, 1);
      start = 1'b1; tick(); start = 1'b0;
      check("la_start_ignored", state_o, 1);
      load_valid = 1'b1; load_data = 8'h99; abort = 1'b1;
      tick(); load_valid = 1'b0; abort = 1'b0;
      check("la_abort_state", state_o, 0);
      check("la_abort_len", prog_len, 0);
      cpu_addr = 4'd0; #1 check("la_fill", cpu_inst, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
